// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter on the core IO store bus: TXDATA pushes into a byte FIFO,
// CTRL holds tx_en/irq_en and a write-1-clear for the sticky overflow flag.
//
//   state | meaning
//   IDLE  | line high, waiting for tx_en and a queued byte
//   START | start bit (low) for BAUD_DIV clocks
//   DATA  | eight data bits, LSB first, BAUD_DIV clocks each
//   STOP  | stop bit (high); chains straight into START when more data is queued
module uart_tx_io #(
    parameter int         BAUD_DIV  = 434,
    parameter int         FIFO_AW   = 4,
    parameter logic [9:0] BASE_WADR = 10'h3F8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         st_adr_io,
    input  logic [31:0]        st_data_io,
    input  logic [3:0]         st_we_io,
    output logic               uart_tx,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               fifo_ovf,
    output logic               irq_tx
);

    localparam int                DEPTH       = 1 << FIFO_AW;
    localparam logic [15:0]       BAUD_RELOAD = 16'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0]  LEVEL_FULL  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_nxt;
    logic [15:0]          baud_cnt, baud_nxt;
    logic [2:0]           bit_idx, bit_nxt;
    logic [7:0]           shifter, shift_nxt;
    logic                 tx_nxt;
    logic                 tx_en, irq_en;
    logic [7:0]           mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;

    logic wr_txdata, wr_ctrl, fifo_empty, fifo_full, baud_zero, pop, push;
    logic unused_bits;

    assign unused_bits = ^{st_data_io[31:8], st_we_io[3:1]};

    assign wr_txdata  = st_we_io[0] && (st_adr_io == BASE_WADR);
    assign wr_ctrl    = st_we_io[0] && (st_adr_io == BASE_WADR + 10'd1);
    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LEVEL_FULL);
    assign baud_zero  = (baud_cnt == 16'd0);

    // A pop happens only on the transition into START, either from IDLE or chained from STOP.
    assign pop  = tx_en && !fifo_empty &&
                  ((state == IDLE) || ((state == STOP) && baud_zero));
    assign push = wr_txdata && (!fifo_full || pop);

    assign tx_busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        baud_nxt  = ((state == IDLE) || baud_zero) ? baud_cnt : baud_cnt - 16'd1;
        bit_nxt   = bit_idx;
        shift_nxt = shifter;
        case (state)
            IDLE: begin
                if (pop) begin
                    shift_nxt = mem[rd_ptr];
                    baud_nxt  = BAUD_RELOAD;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_zero) begin
                    baud_nxt  = BAUD_RELOAD;
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_zero) begin
                    baud_nxt = BAUD_RELOAD;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt   = bit_idx + 3'd1;
                        shift_nxt = {1'b0, shifter[7:1]};
                    end
                end
            end
            STOP: begin
                if (baud_zero) begin
                    if (pop) begin
                        shift_nxt = mem[rd_ptr];
                        baud_nxt  = BAUD_RELOAD;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        tx_nxt = (state_nxt == START) ? 1'b0 :
                 (state_nxt == DATA)  ? shift_nxt[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= st_data_io[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= 16'd0;
            bit_idx    <= 3'd0;
            shifter    <= 8'd0;
            uart_tx    <= 1'b1;
            tx_en      <= 1'b0;
            irq_en     <= 1'b0;
            fifo_ovf   <= 1'b0;
            irq_tx     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shifter  <= shift_nxt;
            uart_tx  <= tx_nxt;
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (FIFO_AW + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (FIFO_AW + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (wr_ctrl) begin
                tx_en  <= st_data_io[0];
                irq_en <= st_data_io[1];
                if (st_data_io[2]) fifo_ovf <= 1'b0;
            end
            if (wr_txdata && fifo_full && !pop) fifo_ovf <= 1'b1;
            irq_tx <= irq_en && fifo_empty && (state == IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io: directed stores feed an expected-byte queue; a serial monitor
// decodes every frame on uart_tx and compares it bit-for-bit against the queue head.
module tb_uart_tx_io;

    localparam int         B    = 4;
    localparam int         AW   = 4;
    localparam logic [9:0] BASE = 10'h3F8;
    localparam logic [9:0] CTRL = BASE + 10'd1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  st_adr_io = '0;
    logic [31:0] st_data_io = '0;
    logic [3:0]  st_we_io = '0;
    logic        uart_tx, tx_busy, fifo_ovf, irq_tx;
    logic [AW:0] fifo_level;

    uart_tx_io #(.BAUD_DIV(B), .FIFO_AW(AW), .BASE_WADR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .st_adr_io(st_adr_io), .st_data_io(st_data_io),
        .st_we_io(st_we_io), .uart_tx(uart_tx), .tx_busy(tx_busy),
        .fifo_level(fifo_level), .fifo_ovf(fifo_ovf), .irq_tx(irq_tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    int          starts[$];
    logic [7:0]  bq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int st(input int i);
        return (starts.size() > i) ? starts[i] : -100000;
    endfunction

    // Serial monitor: each frame is 10*B clocks; checked on every negedge against the expected frame.
    initial begin : monitor
        logic       prev;
        logic [9:0] frame;
        logic [7:0] got, want;
        int         errs;
        bit         aborted, have;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev === 1'b1 && uart_tx === 1'b0) begin
                starts.push_back(cyc);
                have = (exp_q.size() > 0);
                want = have ? exp_q.pop_front() : 8'h00;
                frame = {1'b1, want, 1'b0};
                errs = 0;
                aborted = 0;
                got = 8'h00;
                for (int i = 0; i < 10 * B; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1;
                        break;
                    end
                    if (uart_tx !== frame[i / B]) errs++;
                    if ((i % B) == B / 2 && (i / B) >= 1 && (i / B) <= 8) got[i / B - 1] = uart_tx;
                end
                if (!aborted) begin
                    if (!have) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got 0x%0h expected no frame", got);
                    end else begin
                        check("frame_data", 32'(got), 32'(want));
                        check("frame_bit_errors", errs, 0);
                    end
                end
            end
            prev = uart_tx;
        end
    end

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] we);
        @(posedge clk); #1;
        st_adr_io = a; st_data_io = d; st_we_io = we;
        @(posedge clk); #1;
        st_we_io = 4'b0000;
    endtask

    task automatic burst();
        foreach (bq[i]) begin
            @(posedge clk); #1;
            st_adr_io = BASE; st_data_io = {24'hDEAD5A, bq[i]}; st_we_io = 4'b0001;
        end
        @(posedge clk); #1;
        st_we_io = 4'b0000;
    endtask

    task automatic drain(input string name, output int t_end, output int irq_hits);
        int n = 0;
        irq_hits = 0;
        while ((tx_busy || fifo_level != 0) && n < 3000) begin
            @(posedge clk); #1;
            if (tx_busy && irq_tx) irq_hits++;
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n >= 3000), 32'd0);
        t_end = cyc;
    endtask

    initial begin : stim
        int t, hits;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_tx", uart_tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", fifo_ovf, 0);
        check("rst_irq", irq_tx, 0);
        rst_n = 1'b1;

        // 1: single byte, latency and 40-clock frame
        wr(CTRL, 32'h1, 4'b0001);
        starts.delete();
        exp_q.push_back(8'hA5);
        wr(BASE, 32'hA5, 4'b0001);
        check("t1_level_after_store", fifo_level, 1);
        check("t1_line_idle", uart_tx, 1);
        @(posedge clk); #1;
        check("t1_start_bit", uart_tx, 0);
        check("t1_busy", tx_busy, 1);
        check("t1_level_popped", fifo_level, 0);
        drain("t1", t, hits);
        check("t1_frame_len", t - st(0), 40);
        check("t1_line_high_after", uart_tx, 1);

        // 2: three back-to-back frames, no gap
        starts.delete();
        bq = '{8'h3C, 8'h81, 8'hFF};
        foreach (bq[i]) exp_q.push_back(bq[i]);
        burst();
        drain("t2", t, hits);
        check("t2_frames", starts.size(), 3);
        check("t2_gap01", st(1) - st(0), 40);
        check("t2_gap12", st(2) - st(1), 40);
        check("t2_total", t - st(0), 120);

        // 3: fill with tx disabled, overflow, then clear and send
        wr(CTRL, 32'h0, 4'b0001);
        bq.delete();
        for (int i = 0; i < 17; i++) bq.push_back(8'(8'h10 + i));
        for (int i = 0; i < 16; i++) exp_q.push_back(bq[i]);
        burst();
        check("t3_level_full", fifo_level, 16);
        check("t3_ovf_set", fifo_ovf, 1);
        check("t3_idle_disabled", tx_busy, 0);
        starts.delete();
        wr(CTRL, 32'h5, 4'b0001);
        check("t3_ovf_cleared", fifo_ovf, 0);
        drain("t3", t, hits);
        check("t3_frames", starts.size(), 16);
        check("t3_total", t - st(0), 640);

        // 4: interrupt behaviour
        wr(CTRL, 32'h3, 4'b0001);
        @(posedge clk); #1;
        check("t4_irq_empty_idle", irq_tx, 1);
        exp_q.push_back(8'h5A);
        wr(BASE, 32'h5A, 4'b0001);
        drain("t4", t, hits);
        check("t4_irq_while_busy", hits, 0);
        check("t4_irq_at_stop_end", irq_tx, 0);
        @(posedge clk); #1;
        check("t4_irq_after_stop", irq_tx, 1);
        wr(CTRL, 32'h1, 4'b0001);
        @(posedge clk); #1;
        check("t4_irq_disabled", irq_tx, 0);

        // 5: push into a full FIFO in the same cycle as a pop
        wr(CTRL, 32'h0, 4'b0001);
        bq.delete();
        for (int i = 0; i < 16; i++) bq.push_back(8'(8'hC0 + i));
        foreach (bq[i]) exp_q.push_back(bq[i]);
        burst();
        check("t5_level_full", fifo_level, 16);
        starts.delete();
        @(posedge clk); #1;
        st_adr_io = CTRL; st_data_io = 32'h1; st_we_io = 4'b0001;
        @(posedge clk); #1;
        st_adr_io = BASE; st_data_io = 32'hE7; st_we_io = 4'b0001;
        exp_q.push_back(8'hE7);
        @(posedge clk); #1;
        st_we_io = 4'b0000;
        check("t5_level_push_pop", fifo_level, 16);
        check("t5_no_ovf", fifo_ovf, 0);
        check("t5_busy", tx_busy, 1);
        drain("t5", t, hits);
        check("t5_total", t - st(0), 680);

        // 6: reset mid-frame, then ignored stores
        bq = '{8'h96, 8'h69};
        foreach (bq[i]) exp_q.push_back(bq[i]);
        burst();
        repeat (8) @(posedge clk);
        #1;
        check("t6_mid_data_busy", tx_busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_line", uart_tx, 1);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_busy", tx_busy, 0);
        exp_q.delete();
        rst_n = 1'b1;
        wr(BASE, 32'h33, 4'b1110);
        check("t6_we_hi_no_push", fifo_level, 0);
        wr(BASE + 10'd2, 32'h44, 4'b0001);
        check("t6_other_adr_no_push", fifo_level, 0);
        wr(BASE, 32'h55, 4'b0001);
        check("t6_push_after_rst", fifo_level, 1);
        repeat (2) @(posedge clk);
        #1;
        check("t6_tx_en_cleared", tx_busy, 0);
        check("t6_level_kept", fifo_level, 1);
        check("t6_line_idle", uart_tx, 1);

        check("all_frames_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
